// File: rtl/fifo_dp_1024x18_ctl.sv
// fifo_dp_1024x18_ctl
// Single-clock FIFO controller for an external 1024x18 dual-port block memory.
// Port 0 of the memory is the write port and port 1 is the read port.
// The push side uses valid/ready handshaking. The pop side is first-word-fall-through.
// A 2-entry output buffer hides the memory's one-cycle read latency, so the
// consumer sees one word per cycle once the pipe is primed.

module fifo_dp_1024x18_ctl #(
    parameter int unsigned AFULL_THR = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_valid,
    input  logic [17:0] i_wr_data,
    output logic        o_wr_ready,
    output logic        o_rd_valid,
    output logic [17:0] o_rd_data,
    input  logic        i_rd_ready,
    output logic [10:0] o_level,
    output logic        o_almost_full,
    output logic        o_mem_en0,
    output logic [1:0]  o_mem_wen0,
    output logic [9:0]  o_mem_adr0,
    output logic [17:0] o_mem_wdata0,
    output logic        o_mem_en1,
    output logic [1:0]  o_mem_wen1,
    output logic [9:0]  o_mem_adr1,
    output logic [17:0] o_mem_wdata1,
    input  logic [17:0] i_mem_rdata1
);

    localparam logic [10:0] MEM_DEPTH = 11'd1024;
    localparam logic [10:0] AFULL_LVL = 11'(AFULL_THR);

    // Registered state
    logic [9:0]        wr_ptr;
    logic [9:0]        rd_ptr;
    logic [10:0]       mem_used;    // words resident in the memory, not yet issued
    logic [10:0]       level;       // memory + in-flight read + output buffer
    logic              pending;     // a read was issued on the previous cycle
    logic [1:0][17:0]  obuf;        // obuf[0] is the head
    logic [1:0]        ocnt;
    logic              afull;

    // Combinational next-state and handshake terms
    logic              push;
    logic              pop;
    logic              issue;
    logic [2:0]        committed;   // output-buffer slots claimed after this cycle's pop
    logic [1:0][17:0]  obuf_n;
    logic [1:0]        ocnt_n;
    logic [10:0]       mem_used_n;
    logic [10:0]       level_n;

    // Ready depends only on registered occupancy. A same-cycle pop cannot
    // raise it, because the popped word came from the output buffer, not the memory.
    assign o_wr_ready = (mem_used != MEM_DEPTH);
    assign push       = i_wr_valid & o_wr_ready;

    assign o_rd_valid = (ocnt != 2'd0);
    assign o_rd_data  = obuf[0];
    assign pop        = o_rd_valid & i_rd_ready;

    // A read is issued only if its data will have a free buffer slot on
    // arrival. This counts the word already in flight and the word leaving this cycle.
    // A pop implies ocnt >= 1, so the subtraction cannot underflow.
    assign committed  = {1'b0, ocnt} + {2'b00, pending} - {2'b00, pop};
    assign issue      = (mem_used != 11'd0) && (committed < 3'd2);

    // Memory port 0 is used only for writes.
    assign o_mem_en0    = push;
    assign o_mem_wen0   = push ? 2'b11 : 2'b00;
    assign o_mem_adr0   = wr_ptr;
    assign o_mem_wdata0 = i_wr_data;

    // Memory port 1 is used only for reads. Its address always shows rd_ptr.
    assign o_mem_en1    = issue;
    assign o_mem_wen1   = 2'b00;
    assign o_mem_adr1   = rd_ptr;
    assign o_mem_wdata1 = 18'd0;

    assign o_level       = level;
    assign o_almost_full = afull;

    // Next output-buffer contents: the pop shifts the buffer first, then the
    // returning read word is appended behind whatever remains.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        obuf_n = obuf;
        ocnt_n = ocnt;
        if (pop) begin
            obuf_n[0] = obuf[1];
            ocnt_n    = ocnt - 2'd1;
        end
        if (pending) begin
            obuf_n[ocnt_n[0]] = i_mem_rdata1;
            ocnt_n            = ocnt_n + 2'd1;
        end
    end

    // Occupancy counters
    always_comb begin
        mem_used_n = mem_used + 11'(push) - 11'(issue);
        level_n    = level + 11'(push) - 11'(pop);
    end

    // State register. Reset discards queued words and any read in flight.
    // The memory array itself is left untouched.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_used <= '0;
            level    <= '0;
            pending  <= 1'b0;
            obuf     <= '0;
            ocnt     <= '0;
            afull    <= 1'b0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 10'd1;
            if (issue) rd_ptr <= rd_ptr + 10'd1;
            mem_used <= mem_used_n;
            level    <= level_n;
            pending  <= issue;
            obuf     <= obuf_n;
            ocnt     <= ocnt_n;
            afull    <= (mem_used_n >= AFULL_LVL);
        end
    end

endmodule

// File: tb/tb_fifo_dp_1024x18_ctl.sv
// tb_fifo_dp_1024x18_ctl
// Directed and random stimulus for the FIFO controller, driven against a
// behavioural 1024x18 memory. Each accepted push is queued in a scoreboard,
// and each pop is compared against the head of that queue.

module tb_fifo_dp_1024x18_ctl;

    logic        clk;
    logic        rst;
    logic        i_wr_valid;
    logic [17:0] i_wr_data;
    logic        o_wr_ready;
    logic        o_rd_valid;
    logic [17:0] o_rd_data;
    logic        i_rd_ready;
    logic [10:0] o_level;
    logic        o_almost_full;
    logic        o_mem_en0;
    logic [1:0]  o_mem_wen0;
    logic [9:0]  o_mem_adr0;
    logic [17:0] o_mem_wdata0;
    logic        o_mem_en1;
    logic [1:0]  o_mem_wen1;
    logic [9:0]  o_mem_adr1;
    logic [17:0] o_mem_wdata1;
    logic [17:0] i_mem_rdata1;

    fifo_dp_1024x18_ctl #(.AFULL_THR(1000)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_wr_valid    (i_wr_valid),
        .i_wr_data     (i_wr_data),
        .o_wr_ready    (o_wr_ready),
        .o_rd_valid    (o_rd_valid),
        .o_rd_data     (o_rd_data),
        .i_rd_ready    (i_rd_ready),
        .o_level       (o_level),
        .o_almost_full (o_almost_full),
        .o_mem_en0     (o_mem_en0),
        .o_mem_wen0    (o_mem_wen0),
        .o_mem_adr0    (o_mem_adr0),
        .o_mem_wdata0  (o_mem_wdata0),
        .o_mem_en1     (o_mem_en1),
        .o_mem_wen1    (o_mem_wen1),
        .o_mem_adr1    (o_mem_adr1),
        .o_mem_wdata1  (o_mem_wdata1),
        .i_mem_rdata1  (i_mem_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port memory: two 9-bit byte lanes and one-cycle read latency.
    logic [17:0] mem [1024];
    always @(posedge clk) begin
        if (o_mem_en0) begin
            if (o_mem_wen0[0]) mem[o_mem_adr0][8:0]  <= o_mem_wdata0[8:0];
            if (o_mem_wen0[1]) mem[o_mem_adr0][17:9] <= o_mem_wdata0[17:9];
        end
        if (o_mem_en1) i_mem_rdata1 <= mem[o_mem_adr1];
    end

    // Scoreboard and model state
    logic [17:0] sb[$];
    int          n_checks    = 0;
    int          n_pass      = 0;
    int          n_fail      = 0;
    int          model_level = 0;
    int          push_count  = 0;
    int          pop_count   = 0;
    int          cyc         = 0;
    int          first_valid = -1;
    logic        last_en1    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Outputs are sampled on the falling edge, the model is
    // updated at the rising edge, and inputs may change 1 ns after that edge.
    task automatic tick();
        bit do_push;
        bit do_pop;
        logic [17:0] exp_word;
        @(negedge clk);
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (!rst) begin
            check("level", 32'(o_level), 32'(model_level));
            check("wen1_zero", 32'(o_mem_wen1), 32'd0);
            check("wdata1_zero", 32'(o_mem_wdata1), 32'd0);
            do_push = i_wr_valid && o_wr_ready;
            do_pop  = o_rd_valid && i_rd_ready;
            if (do_push) begin
                check("push_en0", 32'(o_mem_en0), 32'd1);
                check("push_wen0", 32'(o_mem_wen0), 32'd3);
                check("push_wdata0", 32'(o_mem_wdata0), 32'(i_wr_data));
                sb.push_back(i_wr_data);
                push_count++;
            end else begin
                check("idle_en0", 32'(o_mem_en0), 32'd0);
                check("idle_wen0", 32'(o_mem_wen0), 32'd0);
            end
            if (do_pop) begin
                check("pop_has_expect", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_word = sb.pop_front();
                    check("pop_data", 32'(o_rd_data), 32'(exp_word));
                end
                pop_count++;
            end
            if (o_rd_valid && first_valid < 0) first_valid = cyc;
            last_en1 = o_mem_en1;
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            model_level = 0;
        end else begin
            model_level = model_level + int'(do_push) - int'(do_pop);
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        i_wr_valid = 1'b0;
        i_rd_ready = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        i_wr_valid = 1'b0;
        i_rd_ready = 1'b1;
        for (int k = 0; k < 3000 && (sb.size() != 0 || o_rd_valid); k++) tick();
        check({tag, "_empty"}, 32'(sb.size()), 32'd0);
        check({tag, "_level0"}, 32'(o_level), 32'd0);
        check({tag, "_rdvalid0"}, 32'(o_rd_valid), 32'd0);
    endtask

    initial begin
        int start_cyc;
        int n0;
        int p0;
        logic [17:0] lat_words [3];
        lat_words[0] = 18'h00001;
        lat_words[1] = 18'h3FFFF;
        lat_words[2] = 18'h15555;
        rst        = 1'b1;
        i_wr_valid = 1'b0;
        i_wr_data  = '0;
        i_rd_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_wr_ready", 32'(o_wr_ready), 32'd1);
        check("rst_rd_valid", 32'(o_rd_valid), 32'd0);
        check("rst_rd_data", 32'(o_rd_data), 32'd0);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_afull", 32'(o_almost_full), 32'd0);
        check("rst_en0", 32'(o_mem_en0), 32'd0);
        check("rst_en1", 32'(o_mem_en1), 32'd0);

        // Three back-to-back pushes with the consumer always ready
        i_rd_ready  = 1'b1;
        start_cyc   = cyc;
        first_valid = -1;
        for (int i = 0; i < 3; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = lat_words[i];
            tick();
        end
        i_wr_valid = 1'b0;
        n0 = pop_count;
        repeat (3) tick();
        check("lat_first_valid", 32'(first_valid - start_cyc), 32'd3);
        check("lat_b2b_pops", 32'(pop_count - n0), 32'd3);
        check("lat_level0", 32'(o_level), 32'd0);

        // Fill to capacity with the consumer stalled
        do_reset();
        p0 = push_count;
        for (int i = 0; i < 1026; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 18'(i);
            tick();
            if (i == 1000) check("afull_before", 32'(o_almost_full), 32'd0);
            if (i == 1001) check("afull_at_1000", 32'(o_almost_full), 32'd1);
        end
        check("full_pushes", 32'(push_count - p0), 32'd1026);
        check("full_wr_ready", 32'(o_wr_ready), 32'd0);
        check("full_level", 32'(o_level), 32'd1026);
        check("full_rd_valid", 32'(o_rd_valid), 32'd1);
        check("full_head", 32'(o_rd_data), 32'd0);

        // At full, push and pop are requested together: only the pop is accepted
        i_wr_valid = 1'b1;
        i_wr_data  = 18'h3FFFF;
        i_rd_ready = 1'b1;
        p0 = push_count;
        n0 = pop_count;
        tick();
        check("full_no_push", 32'(push_count - p0), 32'd0);
        check("full_pop", 32'(pop_count - n0), 32'd1);
        check("full_ready_back", 32'(o_wr_ready), 32'd1);
        drain("full_drain");
        check("wrap_wr_ptr", 32'(o_mem_adr0), 32'h002);
        check("wrap_rd_ptr", 32'(o_mem_adr1), 32'h002);

        // Random traffic
        for (int i = 0; i < 5000; i++) begin
            i_wr_valid = ($urandom_range(0, 3) != 0);
            i_wr_data  = 18'($urandom);
            i_rd_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        drain("rand_drain");
        check("rand_balance", 32'(push_count - pop_count), 32'd0);

        // Reset while a read is in flight, with 10 words queued
        i_rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 18'(i + 100);
            tick();
        end
        i_wr_valid = 1'b0;
        repeat (4) tick();
        check("mid_rd_valid", 32'(o_rd_valid), 32'd1);
        i_rd_ready = 1'b1;
        tick();
        check("mid_issue", 32'(last_en1), 32'd1);
        i_rd_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rd_valid", 32'(o_rd_valid), 32'd0);
        check("mid_rst_level", 32'(o_level), 32'd0);
        tick();
        check("mid_rst_no_stale", 32'(o_rd_valid), 32'd0);
        i_wr_valid = 1'b1;
        i_wr_data  = 18'h0ABCD;
        i_rd_ready = 1'b1;
        n0 = pop_count;
        tick();
        i_wr_valid = 1'b0;
        for (int k = 0; k < 10 && pop_count == n0; k++) tick();
        check("mid_abcd_popped", 32'(pop_count - n0), 32'd1);
        check("mid_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
